dmem_arbiter: RTL

//  Shares the single data-memory port between the instruction fetch unit (IFU) and
//  the load/store unit (LSU). Sits between the IFU/LSU and the byte-lane memory.

---
 rtl/dmem_arbiter_if.sv | 50 +++++
 rtl/dmem_arbiter.sv | 138 +++++++++++++
 2 files changed

// File: rtl/dmem_arbiter_if.sv
// Bundle of IFU, LSU and memory-side signals around the data-memory arbiter.
// The arbiter takes the slave view; requesters plus memory together take the master view.
interface dmem_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic                  ifu_req_valid;
  logic                  ifu_req_ready;
  logic [ADDR_W-1:0]     ifu_addr;
  logic                  ifu_rsp_valid;
  logic                  ifu_rsp_err;
  logic [DATA_W-1:0]     ifu_rdata;

  logic                  lsu_req_valid;
  logic                  lsu_req_ready;
  logic [ADDR_W-1:0]     lsu_addr;
  logic                  lsu_wen;
  logic [DATA_W-1:0]     lsu_wdata;
  logic [DATA_W/8-1:0]   lsu_wmask;
  logic                  lsu_rsp_valid;
  logic                  lsu_rsp_err;
  logic [DATA_W-1:0]     lsu_rdata;

  logic                  mem_req_valid;
  logic                  mem_req_ready;
  logic [ADDR_W-1:0]     mem_addr;
  logic                  mem_wen;
  logic [DATA_W-1:0]     mem_wdata;
  logic [DATA_W/8-1:0]   mem_wmask;
  logic                  mem_rsp_valid;
  logic [DATA_W-1:0]     mem_rdata;

  modport slave (
    input  ifu_req_valid, ifu_addr,
    input  lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
    input  mem_req_ready, mem_rsp_valid, mem_rdata,
    output ifu_req_ready, ifu_rsp_valid, ifu_rsp_err, ifu_rdata,
    output lsu_req_ready, lsu_rsp_valid, lsu_rsp_err, lsu_rdata,
    output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask
  );

  modport master (
    output ifu_req_valid, ifu_addr,
    output lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
    output mem_req_ready, mem_rsp_valid, mem_rdata,
    input  ifu_req_ready, ifu_rsp_valid, ifu_rsp_err, ifu_rdata,
    input  lsu_req_ready, lsu_rsp_valid, lsu_rsp_err, lsu_rdata,
    input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one data-memory port between IFU and LSU, one transaction
// in flight, with a watchdog that answers with an error if memory never responds.
module dmem_arbiter #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  dmem_arbiter_if.slave    bus
);
  localparam int unsigned MASK_W = DATA_W / 8;
  localparam int unsigned CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic OwnIfu = 1'b0;
  localparam logic OwnLsu = 1'b1;

  typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

  state_e              state_q;
  logic                owner_q;
  logic                last_grant_q;
  logic [CNT_W-1:0]    cnt_q;

  logic                mem_req_valid_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                wen_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [MASK_W-1:0]   wmask_q;

  logic                ifu_rsp_valid_q;
  logic                ifu_rsp_err_q;
  logic [DATA_W-1:0]   ifu_rdata_q;
  logic                lsu_rsp_valid_q;
  logic                lsu_rsp_err_q;
  logic [DATA_W-1:0]   lsu_rdata_q;

  logic grant_ifu;
  logic grant_lsu;
  logic timeout_hit;
  logic finish;

  // Grant is combinational from the valids; forced low while reset is held.
  always_comb begin
    grant_ifu = 1'b0;
    grant_lsu = 1'b0;
    if (state_q == StIdle && !rst) begin
      if (bus.ifu_req_valid && bus.lsu_req_valid) begin
        grant_ifu = (last_grant_q == OwnLsu);
        grant_lsu = (last_grant_q == OwnIfu);
      end else begin
        grant_ifu = bus.ifu_req_valid;
        grant_lsu = bus.lsu_req_valid;
      end
    end
  end

  // Fires on the last allowed WAIT cycle so WAIT never exceeds TIMEOUT cycles.
  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1));
  assign finish      = bus.mem_rsp_valid || timeout_hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= StIdle;
      owner_q         <= OwnIfu;
      last_grant_q    <= OwnLsu;
      cnt_q           <= '0;
      mem_req_valid_q <= 1'b0;
      addr_q          <= '0;
      wen_q           <= 1'b0;
      wdata_q         <= '0;
      wmask_q         <= '0;
      ifu_rsp_valid_q <= 1'b0;
      ifu_rsp_err_q   <= 1'b0;
      ifu_rdata_q     <= '0;
      lsu_rsp_valid_q <= 1'b0;
      lsu_rsp_err_q   <= 1'b0;
      lsu_rdata_q     <= '0;
    end else begin
      ifu_rsp_valid_q <= 1'b0;
      ifu_rsp_err_q   <= 1'b0;
      lsu_rsp_valid_q <= 1'b0;
      lsu_rsp_err_q   <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (grant_ifu || grant_lsu) begin
            addr_q          <= grant_lsu ? bus.lsu_addr : bus.ifu_addr;
            wen_q           <= grant_lsu & bus.lsu_wen;
            wdata_q         <= grant_lsu ? bus.lsu_wdata : '0;
            wmask_q         <= grant_lsu ? bus.lsu_wmask : '0;
            owner_q         <= grant_lsu;
            last_grant_q    <= grant_lsu;
            mem_req_valid_q <= 1'b1;
            state_q         <= StIssue;
          end
        end
        StIssue: begin
          if (bus.mem_req_ready) begin
            mem_req_valid_q <= 1'b0;
            cnt_q           <= '0;
            state_q         <= StWait;
          end
        end
        StWait: begin
          if (finish) begin
            // A real response wins over a coincident timeout.
            if (owner_q == OwnLsu) begin
              lsu_rsp_valid_q <= 1'b1;
              lsu_rsp_err_q   <= !bus.mem_rsp_valid;
              lsu_rdata_q     <= bus.mem_rsp_valid ? bus.mem_rdata : '0;
            end else begin
              ifu_rsp_valid_q <= 1'b1;
              ifu_rsp_err_q   <= !bus.mem_rsp_valid;
              ifu_rdata_q     <= bus.mem_rsp_valid ? bus.mem_rdata : '0;
            end
            state_q <= StIdle;
          end else if (cnt_q != {CNT_W{1'b1}}) begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.ifu_req_ready = grant_ifu;
  assign bus.lsu_req_ready = grant_lsu;
  assign bus.ifu_rsp_valid = ifu_rsp_valid_q;
  assign bus.ifu_rsp_err   = ifu_rsp_err_q;
  assign bus.ifu_rdata     = ifu_rdata_q;
  assign bus.lsu_rsp_valid = lsu_rsp_valid_q;
  assign bus.lsu_rsp_err   = lsu_rsp_err_q;
  assign bus.lsu_rdata     = lsu_rdata_q;
  assign bus.mem_req_valid = mem_req_valid_q;
  assign bus.mem_addr      = addr_q;
  assign bus.mem_wen       = wen_q;
  assign bus.mem_wdata     = wdata_q;
  assign bus.mem_wmask     = wmask_q;
endmodule
